// File: rtl/vend_pkg.sv
// Shared types and coin constants for the vending machine control path.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    COIN_SLUG    = 2'b00,
    COIN_NICKEL  = 2'b01,
    COIN_DIME    = 2'b10,
    COIN_QUARTER = 2'b11
  } coin_code_t;

  localparam logic [5:0] NICKEL  = 6'd5;
  localparam logic [5:0] DIME    = 6'd10;
  localparam logic [5:0] QUARTER = 6'd25;

  // A slug is worth nothing; the caller rejects it before crediting.
  function automatic logic [5:0] coin_value(input coin_code_t code);
    case (code)
      COIN_NICKEL:  coin_value = NICKEL;
      COIN_DIME:    coin_value = DIME;
      COIN_QUARTER: coin_value = QUARTER;
      default:      coin_value = '0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser.sv
// Pays out a loaded amount as nickel pulses separated by one idle cycle.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] amount_i,
  output logic         nickel_o,
  output logic         done_o
);

  logic [W-1:0] remaining_q, remaining_d;
  logic         pulse_q, pulse_d;

  // Each pulse retires one nickel; the following low cycle decides whether another is due.
  always_comb begin
    remaining_d = remaining_q;
    pulse_d     = 1'b0;
    if (load_i) begin
      remaining_d = amount_i;
      pulse_d     = (amount_i != '0);
    end else if (pulse_q) begin
      remaining_d = remaining_q - W'(NICKEL);
    end else if (remaining_q != '0) begin
      pulse_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining_q <= '0;
      pulse_q     <= 1'b0;
    end else begin
      remaining_q <= remaining_d;
      pulse_q     <= pulse_d;
    end
  end

  assign nickel_o = pulse_q;
  assign done_o   = !pulse_q && (remaining_q == '0);

endmodule

// File: rtl/vend_sequencer.sv
// Vending control FSM: credits coins, issues the vend pulse and drives change payout.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int PRICE    = 20,
  parameter int CREDIT_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_code,
  input  logic                cancel,
  output logic                coin_accept,
  output logic                coin_reject,
  output logic                vend,
  output logic                change_nickel,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  if ((PRICE % 5) != 0 || PRICE < 5 || PRICE > 40 || (PRICE + 20) >= (1 << CREDIT_W))
  begin : g_price_check
    $error("vend_sequencer: PRICE must be a multiple of 5 in 5..40 and fit CREDIT_W");
  end

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                accept_q, accept_d;
  logic                reject_q, reject_d;
  logic                vend_q;
  logic                busy_q;
  logic                load;
  logic [CREDIT_W-1:0] loadAmount;
  logic                changeDone;
  coin_code_t          code;

  assign code = coin_code_t'(coin_code);

  // Outputs are registered from the next state so each pulse lines up with its state cycle.
  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    accept_d   = 1'b0;
    reject_d   = 1'b0;
    load       = 1'b0;
    loadAmount = '0;
    case (state_q)
      IDLE, COLLECT: begin
        if (cancel && state_q == COLLECT) begin
          state_d    = CHANGE;
          load       = 1'b1;
          loadAmount = credit_q;
          reject_d   = coin_valid;
        end else if (coin_valid) begin
          if (code == COIN_SLUG) begin
            reject_d = 1'b1;
          end else begin
            accept_d = 1'b1;
            credit_d = credit_q + CREDIT_W'(coin_value(code));
            state_d  = (credit_d >= CREDIT_W'(PRICE)) ? VEND : COLLECT;
          end
        end
      end
      VEND: begin
        reject_d = coin_valid;
        credit_d = credit_q - CREDIT_W'(PRICE);
        if (credit_d != '0) begin
          state_d    = CHANGE;
          load       = 1'b1;
          loadAmount = credit_d;
        end else begin
          state_d = IDLE;
        end
      end
      CHANGE: begin
        reject_d = coin_valid;
        if (change_nickel) begin
          credit_d = credit_q - CREDIT_W'(NICKEL);
        end
        if (changeDone) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      credit_q <= '0;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
      vend_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      accept_q <= accept_d;
      reject_q <= reject_d;
      vend_q   <= (state_d == VEND);
      busy_q   <= (state_d == VEND) || (state_d == CHANGE);
    end
  end

  change_dispenser #(.W(CREDIT_W)) u_change_dispenser (
    .clk      (clk),
    .reset    (reset),
    .load_i   (load),
    .amount_i (loadAmount),
    .nickel_o (change_nickel),
    .done_o   (changeDone)
  );

  assign coin_accept = accept_q;
  assign coin_reject = reject_q;
  assign vend        = vend_q;
  assign credit      = credit_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer at PRICE=20 with hand-computed per-cycle outputs.
module tb_vend_sequencer;

  logic       clk;
  logic       reset;
  logic       coin_valid;
  logic [1:0] coin_code;
  logic       cancel;
  logic       coin_accept;
  logic       coin_reject;
  logic       vend;
  logic       change_nickel;
  logic [5:0] credit;
  logic       busy;

  int checkCount;
  int errorCount;

  localparam logic [1:0] SLUG = 2'b00;
  localparam logic [1:0] NIC  = 2'b01;
  localparam logic [1:0] DIM  = 2'b10;
  localparam logic [1:0] QTR  = 2'b11;

  vend_sequencer #(.PRICE(20), .CREDIT_W(6)) dut (
    .clk           (clk),
    .reset         (reset),
    .coin_valid    (coin_valid),
    .coin_code     (coin_code),
    .cancel        (cancel),
    .coin_accept   (coin_accept),
    .coin_reject   (coin_reject),
    .vend          (vend),
    .change_nickel (change_nickel),
    .credit        (credit),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed as {accept, reject, vend, nickel, busy, credit[5:0]}.
  function automatic logic [31:0] pack(input logic a, input logic r, input logic v,
                                       input logic n, input logic b, input int cred);
    logic [5:0] c;
    c = 6'(cred);
    return {21'b0, a, r, v, n, b, c};
  endfunction

  function automatic logic [31:0] observed();
    return {21'b0, coin_accept, coin_reject, vend, change_nickel, busy, credit};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: observed a/r/v/n/b/credit=%b expected %b", tag, obs[10:0], exp[10:0]);
    end
  endtask

  // Drive one cycle of inputs, let the edge sample them, then clear the strobes.
  task automatic applyStimulus(input logic valid, input logic [1:0] code, input logic cxl);
    coin_valid = valid;
    coin_code  = code;
    cancel     = cxl;
    @(posedge clk);
    #1;
    coin_valid = 1'b0;
    coin_code  = 2'b00;
    cancel     = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    coin_valid = 1'b0;
    coin_code  = 2'b00;
    cancel     = 1'b0;
    reset      = 1'b1;
    #2;
    checkOutput("reset_async", observed(), pack(0,0,0,0,0,0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
    checkOutput("reset_release", observed(), pack(0,0,0,0,0,0));

    $display("[TB] dime + dime");
    applyStimulus(1'b1, DIM, 1'b0);
    checkOutput("dd_first", observed(), pack(1,0,0,0,0,10));
    applyStimulus(1'b1, DIM, 1'b0);
    checkOutput("dd_vend", observed(), pack(1,0,1,0,1,20));
    idle();
    checkOutput("dd_idle", observed(), pack(0,0,0,0,0,0));
    idle();
    checkOutput("dd_quiet", observed(), pack(0,0,0,0,0,0));

    $display("[TB] nickel + quarter");
    applyStimulus(1'b1, NIC, 1'b0);
    checkOutput("nq_nickel", observed(), pack(1,0,0,0,0,5));
    applyStimulus(1'b1, QTR, 1'b0);
    checkOutput("nq_vend", observed(), pack(1,0,1,0,1,30));
    idle(); checkOutput("nq_chg0", observed(), pack(0,0,0,1,1,10));
    idle(); checkOutput("nq_chg1", observed(), pack(0,0,0,0,1,5));
    idle(); checkOutput("nq_chg2", observed(), pack(0,0,0,1,1,5));
    idle(); checkOutput("nq_chg3", observed(), pack(0,0,0,0,1,0));
    idle(); checkOutput("nq_idle", observed(), pack(0,0,0,0,0,0));

    $display("[TB] dime + cancel");
    applyStimulus(1'b1, DIM, 1'b0);
    checkOutput("dc_dime", observed(), pack(1,0,0,0,0,10));
    applyStimulus(1'b0, 2'b00, 1'b1);
    checkOutput("dc_chg0", observed(), pack(0,0,0,1,1,10));
    idle(); checkOutput("dc_chg1", observed(), pack(0,0,0,0,1,5));
    idle(); checkOutput("dc_chg2", observed(), pack(0,0,0,1,1,5));
    idle(); checkOutput("dc_chg3", observed(), pack(0,0,0,0,1,0));
    idle(); checkOutput("dc_idle", observed(), pack(0,0,0,0,0,0));

    $display("[TB] coin with cancel");
    applyStimulus(1'b1, NIC, 1'b0);
    checkOutput("cc_nickel", observed(), pack(1,0,0,0,0,5));
    applyStimulus(1'b1, DIM, 1'b1);
    checkOutput("cc_reject", observed(), pack(0,1,0,1,1,5));
    idle(); checkOutput("cc_chg1", observed(), pack(0,0,0,0,1,0));
    idle(); checkOutput("cc_idle", observed(), pack(0,0,0,0,0,0));

    $display("[TB] slugs and busy rejects");
    applyStimulus(1'b1, SLUG, 1'b0);
    checkOutput("slug_idle", observed(), pack(0,1,0,0,0,0));
    applyStimulus(1'b1, DIM, 1'b0);
    checkOutput("sb_dime", observed(), pack(1,0,0,0,0,10));
    applyStimulus(1'b1, SLUG, 1'b0);
    checkOutput("slug_collect", observed(), pack(0,1,0,0,0,10));
    applyStimulus(1'b1, QTR, 1'b0);
    checkOutput("sb_vend", observed(), pack(1,0,1,0,1,35));
    applyStimulus(1'b1, DIM, 1'b0);
    checkOutput("rej_in_vend", observed(), pack(0,1,0,1,1,15));
    applyStimulus(1'b1, NIC, 1'b0);
    checkOutput("rej_in_change", observed(), pack(0,1,0,0,1,10));
    applyStimulus(1'b0, 2'b00, 1'b1);
    checkOutput("cancel_in_change", observed(), pack(0,0,0,1,1,10));
    idle(); checkOutput("sb_chg3", observed(), pack(0,0,0,0,1,5));
    idle(); checkOutput("sb_chg4", observed(), pack(0,0,0,1,1,5));
    idle(); checkOutput("sb_chg5", observed(), pack(0,0,0,0,1,0));
    idle(); checkOutput("sb_idle", observed(), pack(0,0,0,0,0,0));

    $display("[TB] quarter alone, cancel in idle");
    applyStimulus(1'b1, QTR, 1'b0);
    checkOutput("q_vend", observed(), pack(1,0,1,0,1,25));
    idle(); checkOutput("q_chg0", observed(), pack(0,0,0,1,1,5));
    idle(); checkOutput("q_chg1", observed(), pack(0,0,0,0,1,0));
    idle(); checkOutput("q_idle", observed(), pack(0,0,0,0,0,0));
    applyStimulus(1'b0, 2'b00, 1'b1);
    checkOutput("cancel_idle", observed(), pack(0,0,0,0,0,0));
    idle(); checkOutput("cancel_idle_after", observed(), pack(0,0,0,0,0,0));

    $display("[TB] maximum credit 40");
    applyStimulus(1'b1, NIC, 1'b0);
    applyStimulus(1'b1, DIM, 1'b0);
    checkOutput("max_15", observed(), pack(1,0,0,0,0,15));
    applyStimulus(1'b1, QTR, 1'b0);
    checkOutput("max_vend", observed(), pack(1,0,1,0,1,40));
    for (int i = 0; i < 8; i++) begin
      idle();
      checkOutput($sformatf("max_chg%0d", i), observed(),
                  pack(0,0,0,((i % 2) == 0),1,20 - 5 * ((i + 1) / 2)));
    end
    idle(); checkOutput("max_idle", observed(), pack(0,0,0,0,0,0));

    $display("[TB] reset during change");
    applyStimulus(1'b1, DIM, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b1);
    checkOutput("rc_chg0", observed(), pack(0,0,0,1,1,10));
    idle();
    idle();
    checkOutput("rc_chg2", observed(), pack(0,0,0,1,1,5));
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rc_async_clear", observed(), pack(0,0,0,0,0,0));
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rc_held", observed(), pack(0,0,0,0,0,0));
    reset = 1'b0;
    idle(); checkOutput("rc_after0", observed(), pack(0,0,0,0,0,0));
    idle(); checkOutput("rc_after1", observed(), pack(0,0,0,0,0,0));

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
